// File: rtl/lcd_frame_arbiter.sv
// Frame-level arbiter sharing one PMOD CLS LCD command channel between two text feeders.
// Grants whole frames round-robin, drains the driver between owners, revokes stalled owners.
module lcd_frame_arbiter #(
    parameter int unsigned parm_fast_simulation = 0,
    parameter int unsigned parm_hold_timeout    = 12500
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rst_20mhz,
    input  logic       i_ce_2_5mhz,
    input  logic [1:0] i_req,
    input  logic [1:0] i_wr_clear_display,
    input  logic [1:0] i_wr_text_line1,
    input  logic [1:0] i_wr_text_line2,
    input  logic       i_lcd_command_ready,
    output logic [1:0] o_gnt,
    output logic       o_lcd_wr_clear_display,
    output logic       o_lcd_wr_text_line1,
    output logic       o_lcd_wr_text_line2,
    output logic       o_text_sel,
    output logic       o_timeout_pulse,
    output logic       o_arb_is_idle
);

    localparam int unsigned HoldTimeout = (parm_fast_simulation != 0) ? 250 : parm_hold_timeout;
    localparam logic [23:0] HoldLast    = 24'(HoldTimeout - 1);

    typedef enum logic [1:0] {
        StArbIdle   = 2'd0,
        StArbGrant0 = 2'd1,
        StArbGrant1 = 2'd2,
        StArbDrain  = 2'd3
    } arb_state_e;

    arb_state_e  state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic        ptr_q, ptr_d;
    logic        sel_q, sel_d;
    logic        timeout_q, timeout_d;

    logic        owner;
    logic        winner;
    logic [2:0]  fwd;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;
        owner     = (state_q == StArbGrant1);
        winner    = 1'b0;
        fwd       = 3'b000;

        case (state_q)
            StArbIdle: begin
                if (i_lcd_command_ready && (i_req != 2'b00)) begin
                    // Tie goes to whoever did not own the channel last.
                    winner  = (i_req == 2'b11) ? ~ptr_q : i_req[1];
                    state_d = winner ? StArbGrant1 : StArbGrant0;
                    ptr_d   = winner;
                    sel_d   = winner;
                end
            end
            StArbGrant0, StArbGrant1: begin
                fwd = {i_wr_clear_display[owner], i_wr_text_line1[owner], i_wr_text_line2[owner]};
                if (!i_req[owner]) begin
                    state_d = StArbDrain;
                end else if (timer_q == HoldLast) begin
                    state_d   = StArbDrain;
                    timeout_d = 1'b1;
                end else if (fwd != 3'b000) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            StArbDrain: begin
                if (i_lcd_command_ready) begin
                    state_d = StArbIdle;
                end
            end
            default: begin
                state_d = StArbIdle;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state_q   <= StArbIdle;
            timer_q   <= '0;
            ptr_q     <= 1'b1;
            sel_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // Pulse lasts one system clock regardless of the enable rate.
            timeout_q <= i_ce_2_5mhz & timeout_d;
            if (i_ce_2_5mhz) begin
                state_q <= state_d;
                timer_q <= timer_d;
                ptr_q   <= ptr_d;
                sel_q   <= sel_d;
            end
        end
    end

    always_comb begin
        o_gnt                  = 2'b00;
        o_lcd_wr_clear_display = 1'b0;
        o_lcd_wr_text_line1    = 1'b0;
        o_lcd_wr_text_line2    = 1'b0;
        case (state_q)
            StArbGrant0: begin
                o_gnt                  = 2'b01;
                o_lcd_wr_clear_display = i_wr_clear_display[0];
                o_lcd_wr_text_line1    = i_wr_text_line1[0];
                o_lcd_wr_text_line2    = i_wr_text_line2[0];
            end
            StArbGrant1: begin
                o_gnt                  = 2'b10;
                o_lcd_wr_clear_display = i_wr_clear_display[1];
                o_lcd_wr_text_line1    = i_wr_text_line1[1];
                o_lcd_wr_text_line2    = i_wr_text_line2[1];
            end
            default: begin
                o_gnt = 2'b00;
            end
        endcase
    end

    assign o_text_sel      = sel_q;
    assign o_timeout_pulse = timeout_q;
    assign o_arb_is_idle   = (state_q == StArbIdle);

endmodule
